// File: rtl/sweep_pkg.sv
// Shared types and widths for the stepped-frequency sweep sequencer.
package sweep_pkg;

    localparam int DW         = 28;
    localparam int PW         = 32;
    localparam int NW         = 12;
    localparam int SW         = 24;
    localparam int TC_W       = 5;
    localparam int AVG_LOG2   = 3;
    localparam int AVG_CYCLES = 1 << AVG_LOG2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CAPTURE,
        EMIT,
        STEP,
        DONE
    } state_t;

endpackage

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter; expired is high whenever the count has reached zero.
module sweep_settle_timer
    import sweep_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [SW-1:0] load_value,
    output logic          expired
);

    logic [SW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/sweep_sequencer.sv
// Stepped-frequency sweep controller driving the DDS and lowpass filter.
// Define SWEEP_AVG_EN to average 2^AVG_LOG2 filter samples per point.
module sweep_sequencer
    import sweep_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [PW-1:0]   f_start,
    input  logic [PW-1:0]   f_step,
    input  logic [NW-1:0]   n_points,
    input  logic [SW-1:0]   settle_cycles,
    input  logic [TC_W-1:0] tc_cfg,
    input  logic [DW-1:0]   lp_out,
    output logic [PW-1:0]   dds_data,
    output logic            dds_we,
    output logic            lp_enable,
    output logic [TC_W-1:0] lp_time_constant,
    output logic            lp_clear,
    output logic [DW-1:0]   result_data,
    output logic [NW-1:0]   result_index,
    output logic            result_valid,
    input  logic            result_ready,
    output logic            busy,
    output logic            done
);

    state_t state, next_state;

    logic [PW-1:0]   f_step_q;
    logic [NW-1:0]   n_points_q;
    logic [SW-1:0]   settle_q;
    logic [TC_W-1:0] tc_q;
    logic [NW-1:0]   index;

    logic            accept_start;
    logic            do_load;
    logic            do_step;
    logic            do_capture;
    logic            timer_load;
    logic [SW-1:0]   timer_value;
    logic            timer_expired;

`ifdef SWEEP_AVG_EN
    logic                         acc_clear;
    logic signed [DW+AVG_LOG2-1:0] acc;
    logic signed [DW+AVG_LOG2-1:0] acc_sum;
    logic [DW-1:0]                avg_result;
`endif

    sweep_settle_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .expired    (timer_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        accept_start = 1'b0;
        do_load      = 1'b0;
        do_step      = 1'b0;
        do_capture   = 1'b0;
        timer_load   = 1'b0;
        timer_value  = settle_q;
        lp_enable    = 1'b0;
        result_valid = 1'b0;
        busy         = (state != IDLE);
        done         = (state == DONE);
`ifdef SWEEP_AVG_EN
        acc_clear    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    accept_start = 1'b1;
                    next_state   = LOAD;
                end
            end
            LOAD: begin
                do_load    = 1'b1;
                timer_load = 1'b1;
                next_state = (n_points_q == '0) ? DONE : SETTLE;
            end
            SETTLE: begin
                lp_enable = 1'b1;
                if (timer_expired) begin
                    next_state = CAPTURE;
`ifdef SWEEP_AVG_EN
                    timer_load  = 1'b1;
                    timer_value = SW'(AVG_CYCLES - 1);
                    acc_clear   = 1'b1;
`endif
                end
            end
            CAPTURE: begin
                lp_enable  = 1'b1;
                do_capture = 1'b1;
`ifdef SWEEP_AVG_EN
                if (timer_expired) begin
                    next_state = EMIT;
                end
`else
                next_state = EMIT;
`endif
            end
            EMIT: begin
                lp_enable    = 1'b1;
                result_valid = 1'b1;
                if (result_ready) begin
                    next_state = (index == n_points_q - NW'(1)) ? DONE : STEP;
                end
            end
            STEP: begin
                lp_enable  = 1'b1;
                do_step    = 1'b1;
                timer_load = 1'b1;
                next_state = SETTLE;
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase

        // Abort kills any in-flight work; DONE is left alone so done stays one cycle.
        if (abort && state != IDLE && state != DONE) begin
            next_state   = DONE;
            do_load      = 1'b0;
            do_step      = 1'b0;
            do_capture   = 1'b0;
            timer_load   = 1'b0;
            result_valid = 1'b0;
`ifdef SWEEP_AVG_EN
            acc_clear    = 1'b0;
`endif
        end
    end

`ifdef SWEEP_AVG_EN
    assign acc_sum    = acc + {{AVG_LOG2{lp_out[DW-1]}}, lp_out};
    assign avg_result = DW'(acc_sum >>> AVG_LOG2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (acc_clear) begin
            acc <= '0;
        end else if (do_capture) begin
            acc <= acc_sum;
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_step_q         <= '0;
            n_points_q       <= '0;
            settle_q         <= '0;
            tc_q             <= '0;
            index            <= '0;
            dds_data         <= '0;
            dds_we           <= 1'b0;
            lp_time_constant <= '0;
            lp_clear         <= 1'b0;
            result_data      <= '0;
            result_index     <= '0;
        end else begin
            dds_we   <= 1'b0;
            lp_clear <= 1'b0;
            if (accept_start) begin
                f_step_q   <= f_step;
                n_points_q <= n_points;
                settle_q   <= settle_cycles;
                tc_q       <= tc_cfg;
            end
            // Strobes are registered so they line up with the values they qualify.
            if (do_load) begin
                dds_data         <= f_start;
                dds_we           <= 1'b1;
                lp_time_constant <= tc_q;
                lp_clear         <= 1'b1;
                index            <= '0;
            end
            if (do_step) begin
                dds_data <= dds_data + f_step_q;
                dds_we   <= 1'b1;
                index    <= index + 1'b1;
            end
            if (do_capture) begin
                result_index <= index;
`ifdef SWEEP_AVG_EN
                if (timer_expired) begin
                    result_data <= avg_result;
                end
`else
                result_data <= lp_out;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sweep_sequencer.sv
// Scoreboard bench for sweep_sequencer with a stand-in filter whose output
// depends on the last DDS word and the cycles elapsed since it was written.
module tb_sweep_sequencer;

    localparam int DW = 28;
    localparam int PW = 32;
    localparam int NW = 12;
    localparam int SW = 24;
`ifdef SWEEP_AVG_EN
    localparam int AVG_LAT  = 7;
    localparam int AVG_DATA = 3;
`else
    localparam int AVG_LAT  = 0;
    localparam int AVG_DATA = 0;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [PW-1:0] f_start;
    logic [PW-1:0] f_step;
    logic [NW-1:0] n_points;
    logic [SW-1:0] settle_cycles;
    logic [4:0]    tc_cfg;
    logic [DW-1:0] lp_out;
    logic [PW-1:0] dds_data;
    logic          dds_we;
    logic          lp_enable;
    logic [4:0]    lp_time_constant;
    logic          lp_clear;
    logic [DW-1:0] result_data;
    logic [NW-1:0] result_index;
    logic          result_valid;
    logic          result_ready;
    logic          busy;
    logic          done;

    typedef struct {
        logic [NW-1:0] idx;
        logic [DW-1:0] data;
    } res_t;

    res_t          exp_res[$];
    logic [PW-1:0] exp_dds[$];
    logic [4:0]    exp_tc;
    int            errors;
    int            checks;
    int            clear_count;

    logic [PW-1:0] filt_freq;
    int unsigned   filt_tick;

    sweep_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .f_start          (f_start),
        .f_step           (f_step),
        .n_points         (n_points),
        .settle_cycles    (settle_cycles),
        .tc_cfg           (tc_cfg),
        .lp_out           (lp_out),
        .dds_data         (dds_data),
        .dds_we           (dds_we),
        .lp_enable        (lp_enable),
        .lp_time_constant (lp_time_constant),
        .lp_clear         (lp_clear),
        .result_data      (result_data),
        .result_index     (result_index),
        .result_valid     (result_valid),
        .result_ready     (result_ready),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mix(input logic [PW-1:0] f);
        return {{(DW-20){f[PW-1]}}, f[PW-1 -: 20]};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_freq <= '0;
            filt_tick <= 0;
        end else if (dds_we) begin
            filt_freq <= dds_data;
            filt_tick <= 1;
        end else begin
            filt_tick <= filt_tick + 1;
        end
    end

    assign lp_out = mix(filt_freq) + DW'(filt_tick);

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportMissing(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got an output event, expected none queued", name);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (dds_we) begin
                if (exp_dds.size() == 0) begin
                    reportMissing("dds_we_unexpected");
                end else begin
                    checkOutput("dds_data", dds_data, exp_dds.pop_front());
                    checkOutput("lp_time_constant", lp_time_constant, exp_tc);
                end
            end
            if (lp_clear) clear_count++;
            if (result_valid && result_ready) begin
                if (exp_res.size() == 0) begin
                    reportMissing("result_unexpected");
                end else begin
                    res_t r;
                    r = exp_res.pop_front();
                    checkOutput("result_index", result_index, r.idx);
                    checkOutput("result_data", result_data, r.data);
                    checkOutput("lp_enable_emit", lp_enable, 1'b1);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [PW-1:0] fs, input logic [PW-1:0] fstep, input int n,
                                 input int settle, input logic [4:0] tc, input int abort_point,
                                 input bit random_ready, input bit hold);
        int            cyc, first_valid, done_cycle, abort_cycle, abort_wait;
        int            writes, done_pulses, hold_left, clears0, budget;
        bit            hold_started, hold_ok, timed_out;
        logic [DW-1:0] snap_data;
        logic [NW-1:0] snap_idx;
        logic [PW-1:0] f, last_f;
        res_t          r;

        last_f = fs;
        for (int i = 0; i < n; i++) begin
            if (abort_point >= 0 && i > abort_point) break;
            f = fs + fstep * PW'(i);
            exp_dds.push_back(f);
            last_f = f;
            if (i != abort_point) begin
                r.idx  = NW'(i);
                r.data = mix(f) + DW'(settle + 1 + AVG_DATA);
                exp_res.push_back(r);
            end
        end
        if (n == 0) exp_dds.push_back(fs);
        exp_tc = tc;

        first_valid  = -1;
        done_cycle   = -1;
        abort_cycle  = -1;
        abort_wait   = -1;
        writes       = 0;
        done_pulses  = 0;
        hold_left    = 0;
        hold_started = 1'b0;
        hold_ok      = 1'b1;
        timed_out    = 1'b0;
        snap_data    = '0;
        snap_idx     = '0;
        clears0      = clear_count;
        budget       = (n + 2) * (settle + AVG_LAT + 40) * 2;

        @(posedge clk); #1;
        f_start       = fs;
        f_step        = fstep;
        n_points      = NW'(n);
        settle_cycles = SW'(settle);
        tc_cfg        = tc;
        result_ready  = 1'b1;
        start         = 1'b1;
        cyc = 0;
        while (1) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc > budget) begin
                timed_out = 1'b1;
                checks++;
                errors++;
                $display("[TB] FAIL sweep_timeout: got no done after %0d cycles, expected done", budget);
                break;
            end
            if (dds_we) begin
                writes++;
                if (abort_point >= 0 && writes == abort_point + 1) abort_wait = 2;
            end
            if (result_valid && first_valid < 0) first_valid = cyc;
            if (done) begin
                done_pulses++;
                done_cycle = cyc;
                break;
            end
            if (hold && !hold_started && result_valid) begin
                hold_started = 1'b1;
                hold_left    = 20;
                snap_data    = result_data;
                snap_idx     = result_index;
            end
            if (hold_left > 0) begin
                if (!result_valid || result_data !== snap_data || result_index !== snap_idx || dds_we)
                    hold_ok = 1'b0;
                hold_left--;
                result_ready = 1'b0;
            end else begin
                result_ready = random_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            start = busy && ($urandom_range(0, 7) == 0);
            if (abort_wait == 0) begin
                abort       = 1'b1;
                abort_cycle = cyc;
                abort_wait  = -1;
            end else begin
                abort = 1'b0;
                if (abort_wait > 0) abort_wait--;
            end
            if (cyc >= 2) begin
                f_start       = $urandom;
                f_step        = $urandom;
                n_points      = NW'($urandom);
                settle_cycles = SW'($urandom);
                tc_cfg        = 5'($urandom);
            end
        end
        start        = 1'b0;
        abort        = 1'b0;
        result_ready = 1'b1;

        @(posedge clk); #1;
        checkOutput("idle_after_done", {busy, done, lp_enable, result_valid}, 4'b0000);
        repeat (2) begin
            @(posedge clk); #1;
            if (done) done_pulses++;
        end

        if (!timed_out) begin
            checkOutput("done_pulses", done_pulses, 1);
            if (n == 0) begin
                checkOutput("zero_pt_done_cycle", done_cycle, 2);
                checkOutput("zero_pt_first_valid", first_valid, -1);
            end else if (abort_point != 0) begin
                checkOutput("first_valid_latency", first_valid, settle + 4 + AVG_LAT);
            end
            if (abort_point >= 0) checkOutput("abort_done_cycle", done_cycle, abort_cycle + 1);
            if (hold) checkOutput("hold_stable", hold_ok && hold_started, 1'b1);
            checkOutput("lp_clear_pulses", clear_count - clears0, 1);
            checkOutput("dds_hold_idle", dds_data, last_f);
            checkOutput("tc_hold_idle", lp_time_constant, tc);
        end
        checkOutput("result_queue_empty", exp_res.size(), 0);
        checkOutput("dds_queue_empty", exp_dds.size(), 0);
        exp_res.delete();
        exp_dds.delete();
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        clear_count   = 0;
        exp_tc        = '0;
        reset         = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        f_start       = '0;
        f_step        = '0;
        n_points      = '0;
        settle_cycles = '0;
        tc_cfg        = '0;
        result_ready  = 1'b1;
        #1;
        checkOutput("reset_outputs",
                    {dds_data, dds_we, lp_enable, lp_time_constant, lp_clear, result_data,
                     result_index, result_valid, busy, done}, '0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        applyStimulus(32'h0100_0000, 32'h0010_0000, 3, 10, 5'd7, -1, 1'b0, 1'b0);
        applyStimulus(32'h1234_5678, 32'h0000_0010, 0, 5, 5'd3, -1, 1'b0, 1'b0);
        applyStimulus(32'h0200_0000, 32'h0001_0000, 2, 3, 5'd9, -1, 1'b0, 1'b1);
        applyStimulus(32'h0300_0000, 32'h0002_0000, 4, 8, 5'd11, 1, 1'b0, 1'b0);
        applyStimulus(32'hFFFF_FFF0, 32'h0000_0020, 2, 2, 5'd1, -1, 1'b1, 1'b0);

        @(posedge clk); #1;
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(posedge clk); #1;
        checkOutput("start_abort_idle", {busy, dds_we, lp_clear}, 3'b000);

        exp_tc = 5'd4;
        exp_dds.push_back(32'h0400_0000);
        @(posedge clk); #1;
        f_start       = 32'h0400_0000;
        f_step        = 32'h0000_0100;
        n_points      = NW'(2);
        settle_cycles = SW'(3);
        tc_cfg        = 5'd4;
        result_ready  = 1'b0;
        start         = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 40 && !result_valid; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("reached_emit", result_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_outputs",
                    {dds_data, dds_we, lp_enable, lp_time_constant, lp_clear, result_data,
                     result_index, result_valid, busy, done}, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_res.delete();
        exp_dds.delete();
        result_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_after_reset", busy, 1'b0);
        applyStimulus(32'h0500_0000, 32'h0003_0000, 3, 4, 5'd13, -1, 1'b1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            applyStimulus($urandom, $urandom, $urandom_range(1, 5), $urandom_range(0, 12),
                          5'($urandom), -1, 1'b1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
